// File: rtl/cache_mem_arbiter.sv
// Shares one memory word port between the icache miss path and the dcache miss/writeback path.
// Latency: strobes rise the cycle after a request is seen in IDLE; resp is combinational from mem_resp.
// Backpressure: requests are held until resp; the loser of contention waits, and the grant is held until mem_resp.
module cache_mem_arbiter #(
  parameter int WIDTH     = 16,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  // icache side
  input  logic                 i_read,
  input  logic [WIDTH-1:0]     i_address,
  output logic [WIDTH-1:0]     i_rdata,
  output logic                 i_resp,
  // dcache side
  input  logic                 d_read,
  input  logic                 d_write,
  input  logic [WIDTH-1:0]     d_address,
  input  logic [WIDTH-1:0]     d_wdata,
  output logic [WIDTH-1:0]     d_rdata,
  output logic                 d_resp,
  // memory side
  output logic                 mem_read,
  output logic                 mem_write,
  output logic [WIDTH-1:0]     mem_address,
  output logic [WIDTH-1:0]     mem_wdata,
  input  logic [WIDTH-1:0]     mem_rdata,
  input  logic                 mem_resp,
  // performance statistic
  output logic [CNT_WIDTH-1:0] conflict_count
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } state_t;

  typedef enum logic {
    GRANT_I = 1'b0,
    GRANT_D = 1'b1
  } grant_t;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  state_t               state, state_nxt;
  grant_t               last_grant, last_grant_nxt;
  logic [CNT_WIDTH-1:0] cnt, cnt_nxt;
  logic                 i_pend, d_pend;

  assign i_pend = i_read;
  assign d_pend = d_read | d_write;

  // Read data is a plain broadcast; only the resp pulse carries ownership.
  assign i_rdata        = mem_rdata;
  assign d_rdata        = mem_rdata;
  assign conflict_count = cnt;

  // State, round-robin pointer and contention counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= GRANT_I;
      cnt        <= '0;
    end else begin
      state      <= state_nxt;
      last_grant <= last_grant_nxt;
      cnt        <= cnt_nxt;
    end
  end

  // Arbitration decision and memory-side/resp steering for the current owner.
  always_comb begin
    state_nxt      = state;
    last_grant_nxt = last_grant;
    cnt_nxt        = cnt;
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    mem_address    = '0;
    mem_wdata      = '0;
    i_resp         = 1'b0;
    d_resp         = 1'b0;

    case (state)
      IDLE: begin
        // mem_resp is deliberately ignored here: nobody owns the port.
        if (i_pend && d_pend) begin
          // Give the port to whichever side did not win last time.
          if (last_grant == GRANT_I) begin
            state_nxt      = SERVE_D;
            last_grant_nxt = GRANT_D;
          end else begin
            state_nxt      = SERVE_I;
            last_grant_nxt = GRANT_I;
          end
          if (cnt != CNT_MAX) begin
            cnt_nxt = cnt + CNT_ONE;
          end
        end else if (i_pend) begin
          state_nxt      = SERVE_I;
          last_grant_nxt = GRANT_I;
        end else if (d_pend) begin
          state_nxt      = SERVE_D;
          last_grant_nxt = GRANT_D;
        end
      end

      SERVE_I: begin
        // Strobes follow the live request; the grant is held until memory answers.
        mem_read    = i_read;
        mem_address = i_address;
        i_resp      = mem_resp;
        if (mem_resp) begin
          state_nxt = IDLE;
        end
      end

      SERVE_D: begin
        // Read+write together is resolved as a write.
        mem_read    = d_read & ~d_write;
        mem_write   = d_write;
        mem_address = d_address;
        mem_wdata   = d_wdata;
        d_resp      = mem_resp;
        if (mem_resp) begin
          state_nxt = IDLE;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: doc/cache_mem_arbiter.md
Name: cache_mem_arbiter

Overview:
- Two-port arbiter that shares the single physical-memory word port between the icache miss path and the dcache miss/writeback path.
- Sits between the two caches and the memory-side interface that feeds the counter-intercept I/O block.
- Three-state FSM, round-robin on contention, grant held until memory responds.
- Exports a saturating contention counter so software can read it as a performance statistic.

Parameters:
- WIDTH, 16, data and address width; matches lc3b_word.
- CNT_WIDTH, 16, width of conflict_count.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- i_read  in  1  icache read request; held until i_resp.
- i_address  in  WIDTH  icache address.
- i_rdata  out  WIDTH  read data to icache.
- i_resp  out  1  icache transaction complete; one-cycle pulse.
- d_read  in  1  dcache read request; held until d_resp.
- d_write  in  1  dcache write request; held until d_resp.
- d_address  in  WIDTH  dcache address.
- d_wdata  in  WIDTH  dcache write data.
- d_rdata  out  WIDTH  read data to dcache.
- d_resp  out  1  dcache transaction complete; one-cycle pulse.
- mem_read  out  1  read strobe to memory side.
- mem_write  out  1  write strobe to memory side.
- mem_address  out  WIDTH  address to memory side.
- mem_wdata  out  WIDTH  write data to memory side.
- mem_rdata  in  WIDTH  read data from memory side.
- mem_resp  in  1  memory transaction complete.
- conflict_count  out  CNT_WIDTH  saturating count of contended arbitration cycles.

Behaviour:
- Reset: synchronous; takes priority over every other event in the same cycle.
  - State goes to IDLE, last_grant goes to ICACHE (so dcache wins the first contention), conflict_count goes to 0.
  - All request outputs (mem_read, mem_write, i_resp, d_resp) are 0 in the cycle after reset is sampled.
  - Reset during SERVE abandons the transaction: no resp is ever issued for it, and memory sees its strobes drop.
- Pending requests:
  - i_pend = i_read.
  - d_pend = d_read | d_write.
  - d_read and d_write both high is illegal; it is treated as a write and mem_read stays 0.
- IDLE state:
  - mem_read/mem_write = 0; mem_address/mem_wdata are don't-care and driven to 0.
  - Only i_pend: next state SERVE_I.
  - Only d_pend: next state SERVE_D.
  - Both pending: grant the requester other than last_grant, and conflict_count += 1 (saturating at all-ones, no wrap).
  - last_grant updates to the granted requester on the IDLE->SERVE transition.
- SERVE_I state:
  - mem_read = i_read, mem_write = 0, mem_address = i_address.
  - i_rdata = mem_rdata and i_resp = mem_resp, both combinational.
  - d_resp = 0.
  - On mem_resp the FSM returns to IDLE.
- SERVE_D state:
  - mem_read = d_read & ~d_write, mem_write = d_write, mem_address = d_address, mem_wdata = d_wdata.
  - d_rdata = mem_rdata and d_resp = mem_resp.
  - i_resp = 0.
  - On mem_resp the FSM returns to IDLE.
- Rdata when not granted: i_rdata/d_rdata equal mem_rdata at all times; only the resp is gated by grant.
- Latency:
  - A request seen in IDLE drives memory strobes from the next cycle.
  - Minimum transaction is 2 cycles plus memory latency.
  - There is one mandatory IDLE bubble between consecutive grants, including back-to-back requests from the same requester.
- Grant is non-preemptive: a new request from the other port during SERVE waits; it is not counted as a conflict unless both are pending in IDLE.
- Requester dropping its request mid-SERVE violates protocol. The arbiter does not check for it; strobes follow the live inputs and the FSM still waits for mem_resp.
- mem_resp arriving in IDLE is ignored: no resp to either side, no state change.
- conflict_count at all-ones stays at all-ones on further contention.

Test Plan:
- Reset, then idle 3 cycles -> all strobes/resps 0, conflict_count = 0; state IDLE.
- i_read at 0x1000 alone, memory responds 3 cycles after mem_read rises with 0xBEEF -> mem_address = 0x1000, i_resp pulses once with i_rdata = 0xBEEF, d_resp stays 0.
- d_write to 0x2002 with 0x55AA -> mem_write = 1, mem_wdata = 0x55AA, mem_read = 0; d_resp pulses once; then d_read of 0x2002 sees one IDLE bubble before mem_read rises.
- i_read and d_read asserted together after reset -> dcache served first, conflict_count = 1. Both re-asserted: icache is served first next time (round-robin), conflict_count = 2.
- Assert reset while in SERVE_D before mem_resp -> next cycle mem_read/mem_write = 0, no d_resp; a fresh d_read afterwards completes normally.
- Preload conflict_count near saturation via repeated contention (CNT_WIDTH=4 build) -> count stops at 0xF. Also: d_read and d_write both high -> only mem_write asserted.
